// File: rtl/rx_descram_packer_pkg.sv
// Shared definitions for the OFDM receive-side descrambler/byte packer:
// FSM encoding, SIGNAL field layout and 802.11a frame constants.
package rx_descram_packer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SIG,
    PL_SEED,
    PL_SVC,
    PL_DATA,
    PL_DRAIN
  } state_t;

  localparam int HDR_BITS  = 24;
  localparam int SEED_BITS = 7;
  localparam int SVC_BITS  = 16;
  localparam int TAIL_BITS = 6;

  // SIGNAL field layout, first received bit is bit 0
  localparam int RATE_LSB   = 0;
  localparam int RATE_W     = 4;
  localparam int RSVD_BIT   = 4;
  localparam int LEN_LSB    = 5;
  localparam int PARITY_BIT = 17;
  localparam int TAIL_LSB   = 18;

  // Only bits below the tail carry information worth storing
  localparam int HDR_KEEP = TAIL_LSB;

  // Largest LENGTH whose SERVICE + PSDU + tail still fits the payload
  function automatic int max_len_bytes(input int payload_bits);
    return (payload_bits - SVC_BITS - TAIL_BITS) / 8;
  endfunction

endpackage

// File: rtl/rx_descram_packer_if.sv
// Bit-serial input side and packed byte output side of rx_descram_packer.
// master = upstream receiver/consumer side, slave = the packer itself.
interface rx_descram_packer_if #(
  parameter int LEN_W = 12
) ();

  logic             sig_bit;
  logic             sig_vld;
  logic             pl_bit;
  logic             pl_vld;
  logic             hdr_vld;
  logic             hdr_err;
  logic [3:0]       rate;
  logic [LEN_W-1:0] length;
  logic [7:0]       byte_out;
  logic             byte_vld;
  logic             byte_sop;
  logic             byte_eop;
  logic             busy;

  modport master (
    output sig_bit, sig_vld, pl_bit, pl_vld,
    input  hdr_vld, hdr_err, rate, length,
    input  byte_out, byte_vld, byte_sop, byte_eop, busy
  );

  modport slave (
    input  sig_bit, sig_vld, pl_bit, pl_vld,
    output hdr_vld, hdr_err, rate, length,
    output byte_out, byte_vld, byte_sop, byte_eop, busy
  );

endinterface

// File: rtl/rx_descrambler.sv
// x^7 + x^4 + 1 self-synchronising seed recovery and descrambler.
// load shifts received bits in as seed; step descrambles one bit.
module rx_descrambler
  import rx_descram_packer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic din,
  output logic dout
);

  logic [SEED_BITS-1:0] scr;
  logic                 fb;

  assign fb   = scr[6] ^ scr[3];
  assign dout = din ^ fb;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      scr <= '0;
    end else if (load) begin
      scr <= {scr[SEED_BITS-2:0], din};
    end else if (step) begin
      scr <= {scr[SEED_BITS-2:0], fb};
    end
  end

endmodule

// File: rtl/rx_descram_packer.sv
// Parses the serial SIGNAL header, recovers the scrambler seed from SERVICE,
// descrambles the PSDU and emits LSB-first packed bytes with sop/eop.
module rx_descram_packer
  import rx_descram_packer_pkg::*;
#(
  parameter int PAYLOAD_BITS = 4320,
  parameter int LEN_W        = 12
) (
  input  logic               clk,
  input  logic               rst,
  rx_descram_packer_if.slave io
);

  localparam int                PCNT_W    = $clog2(PAYLOAD_BITS);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PAYLOAD_BITS - 1);
  localparam logic [PCNT_W-1:0] SEED_LAST = PCNT_W'(SEED_BITS - 1);
  localparam logic [PCNT_W-1:0] SVC_LAST  = PCNT_W'(SVC_BITS - 1);
  localparam logic [4:0]        SIG_DONE  = 5'(HDR_BITS);
  localparam logic [4:0]        SIG_KEEP  = 5'(HDR_KEEP);
  localparam int                MAX_LEN   = max_len_bytes(PAYLOAD_BITS);

  state_t state, state_nxt;

  logic [HDR_KEEP-1:0] hdr_sr;
  logic [4:0]          sig_cnt;
  logic [PCNT_W-1:0]   pcnt;
  logic [2:0]          bit_cnt;
  logic [LEN_W-1:0]    byte_cnt;
  logic [6:0]          pack;

  logic                hdr_vld_r;
  logic                hdr_err_r;
  logic [RATE_W-1:0]   rate_r;
  logic [LEN_W-1:0]    length_r;
  logic [7:0]          byte_r;
  logic                byte_vld_r;
  logic                byte_sop_r;
  logic                byte_eop_r;

  logic                sig_shift;
  logic                hdr_done;
  logic                hdr_ok;
  logic                seed_load;
  logic                desc_step;
  logic                data_bit;
  logic                byte_done;
  logic                last_byte;
  logic                pl_adv;
  logic                dout;
  logic [RATE_W-1:0]   hdr_rate;
  logic [LEN_W-1:0]    hdr_len;

  rx_descrambler u_descrambler (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .step (desc_step),
    .din  (io.pl_bit),
    .dout (dout)
  );

  // Header checks: even parity over bits 0..17, legal rate, reserved clear,
  // and a LENGTH that fits SERVICE + PSDU + tail inside the payload.
  assign hdr_rate = hdr_sr[RATE_LSB +: RATE_W];
  assign hdr_len  = hdr_sr[LEN_LSB +: LEN_W];
  assign hdr_ok   = !(^hdr_sr) && hdr_rate[RATE_W-1] && !hdr_sr[RSVD_BIT] &&
                    (hdr_len != '0) && (int'(hdr_len) <= MAX_LEN);

  assign last_byte = (byte_cnt == length_r - 1'b1);
  assign pl_adv    = io.pl_vld && (state inside {PL_SEED, PL_SVC, PL_DATA, PL_DRAIN});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    sig_shift = 1'b0;
    hdr_done  = 1'b0;
    seed_load = 1'b0;
    desc_step = 1'b0;
    data_bit  = 1'b0;
    byte_done = 1'b0;
    case (state)
      IDLE: begin
        if (io.sig_vld) begin
          sig_shift = 1'b1;
          state_nxt = SIG;
        end
      end
      SIG: begin
        if (sig_cnt == SIG_DONE) begin
          hdr_done  = 1'b1;
          state_nxt = hdr_ok ? PL_SEED : PL_DRAIN;
        end else if (io.sig_vld) begin
          sig_shift = 1'b1;
        end
      end
      PL_SEED: begin
        if (io.pl_vld) begin
          seed_load = 1'b1;
          if (pcnt == SEED_LAST) state_nxt = PL_SVC;
        end
      end
      PL_SVC: begin
        if (io.pl_vld) begin
          desc_step = 1'b1;
          if (pcnt == SVC_LAST) state_nxt = PL_DATA;
        end
      end
      PL_DATA: begin
        if (io.pl_vld) begin
          desc_step = 1'b1;
          data_bit  = 1'b1;
          if (bit_cnt == 3'd7) begin
            byte_done = 1'b1;
            if (last_byte) state_nxt = PL_DRAIN;
          end
        end
      end
      PL_DRAIN: begin
        if (io.pl_vld && (pcnt == PCNT_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_sr     <= '0;
      sig_cnt    <= '0;
      pcnt       <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      pack       <= '0;
      hdr_vld_r  <= 1'b0;
      hdr_err_r  <= 1'b0;
      rate_r     <= '0;
      length_r   <= '0;
      byte_r     <= '0;
      byte_vld_r <= 1'b0;
      byte_sop_r <= 1'b0;
      byte_eop_r <= 1'b0;
    end else begin
      // After HDR_KEEP shifts the first received bit sits at hdr_sr[0]
      if (sig_shift && (sig_cnt < SIG_KEEP)) hdr_sr <= {io.sig_bit, hdr_sr[HDR_KEEP-1:1]};
      if (hdr_done) begin
        sig_cnt  <= '0;
        pcnt     <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (sig_shift) begin
        sig_cnt <= sig_cnt + 1'b1;
      end

      hdr_vld_r <= hdr_done && hdr_ok;
      hdr_err_r <= hdr_done && !hdr_ok;
      if (hdr_done && hdr_ok) begin
        rate_r   <= hdr_rate;
        length_r <= hdr_len;
      end

      if (pl_adv) pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;

      if (data_bit) begin
        pack    <= {dout, pack[6:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (byte_done) begin
        byte_r   <= {dout, pack};
        byte_cnt <= byte_cnt + 1'b1;
      end
      byte_vld_r <= byte_done;
      byte_sop_r <= byte_done && (byte_cnt == '0);
      byte_eop_r <= byte_done && last_byte;
    end
  end

  assign io.hdr_vld  = hdr_vld_r;
  assign io.hdr_err  = hdr_err_r;
  assign io.rate     = rate_r;
  assign io.length   = length_r;
  assign io.byte_out = byte_r;
  assign io.byte_vld = byte_vld_r;
  assign io.byte_sop = byte_sop_r;
  assign io.byte_eop = byte_eop_r;
  assign io.busy     = (state != IDLE);

endmodule

// File: tb/tb_rx_descram_packer.sv
// Directed bench for rx_descram_packer: a transmit-side scrambler model builds
// each payload, captured bytes are compared against the original PSDU.
module tb_rx_descram_packer;

  localparam int PAYLOAD_BITS = 4320;
  localparam int LEN_W        = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rx_descram_packer_if #(.LEN_W(LEN_W)) bus ();

  rx_descram_packer #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .LEN_W        (LEN_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       sop;
    logic       eop;
    int         cyc;
  } byte_rec_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         hvld_cnt = 0;
  int         herr_cnt = 0;
  int         stray    = 0;
  int         drv_cyc;
  int         last_data_cyc;
  byte_rec_t  got_q[$];
  byte_rec_t  mon_rec;
  logic [7:0] psdu[0:599];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.byte_vld) begin
      mon_rec.b   = bus.byte_out;
      mon_rec.sop = bus.byte_sop;
      mon_rec.eop = bus.byte_eop;
      mon_rec.cyc = cyc;
      got_q.push_back(mon_rec);
    end
    if ((bus.byte_sop || bus.byte_eop) && !bus.byte_vld) stray++;
    if (bus.hdr_vld) hvld_cnt++;
    if (bus.hdr_err) herr_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] make_hdr(input logic [3:0] rate, input logic [11:0] len,
                                           input logic rsvd, input logic flip_par);
    logic [23:0] h;
    h        = '0;
    h[3:0]   = rate;
    h[4]     = rsvd;
    h[16:5]  = len;
    h[17]    = (^h[16:0]) ^ flip_par;
    return h;
  endfunction

  task automatic send_hdr(input logic [23:0] h);
    for (int i = 0; i < 24; i++) begin
      bus.sig_bit = h[i];
      bus.sig_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.sig_vld = 1'b0;
    bus.sig_bit = 1'b0;
  endtask

  task automatic wait_hdr(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge clk);
      seen = bus.hdr_vld || bus.hdr_err;
    end
    check({tag, "_hdr_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    bus.pl_bit = b;
    bus.pl_vld = 1'b1;
    drv_cyc    = cyc;
    @(posedge clk);
    #1;
    bus.pl_vld = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transmit model: SERVICE zeros, PSDU LSB-first, zero tail/pad, scrambled
  task automatic send_payload(input logic [6:0] seed, input int len, input bit gap,
                              input int nbits);
    logic [6:0] s;
    logic [7:0] cur;
    logic [9:0] bi;
    logic       d;
    logic       fb;
    s = seed;
    for (int i = 0; i < nbits; i++) begin
      d = 1'b0;
      if (i >= 16 && i < 16 + 8 * len) begin
        bi  = 10'((i - 16) / 8);
        cur = psdu[bi] >> ((i - 16) % 8);
        d   = cur[0];
      end
      fb = s[6] ^ s[3];
      s  = {s[5:0], fb};
      if (i == PAYLOAD_BITS - 1) check("busy_before_last", 32'(bus.busy), 32'd1);
      send_bit(d ^ fb, gap);
      if (i == 16 + 8 * len - 1) last_data_cyc = drv_cyc;
    end
  endtask

  task automatic check_bytes(input string tag, input int base, input int n, input int frame_len);
    byte_rec_t r;
    check({tag, "_nbytes"}, 32'(got_q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < got_q.size(); i++) begin
      r = got_q[base + i];
      check($sformatf("%s_data%0d", tag, i), 32'(r.b), 32'(psdu[i]));
      check($sformatf("%s_sop%0d", tag, i), 32'(r.sop), 32'(i == 0));
      check($sformatf("%s_eop%0d", tag, i), 32'(r.eop), 32'(i == frame_len - 1));
    end
  endtask

  task automatic run_accept(input string tag, input logic [3:0] rate, input int len,
                            input logic [6:0] seed, input bit gap);
    int hb, eb, qb;
    hb = hvld_cnt;
    eb = herr_cnt;
    qb = got_q.size();
    send_hdr(make_hdr(rate, 12'(len), 1'b0, 1'b0));
    wait_hdr(tag);
    check({tag, "_hdr_vld"}, 32'(hvld_cnt - hb), 32'd1);
    check({tag, "_hdr_err"}, 32'(herr_cnt - eb), 32'd0);
    check({tag, "_rate"}, 32'(bus.rate), 32'(rate));
    check({tag, "_length"}, 32'(bus.length), 32'(len));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    send_payload(seed, len, gap, PAYLOAD_BITS);
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    check_bytes(tag, qb, len, len);
  endtask

  task automatic run_reject(input string tag, input logic [23:0] h);
    int hb, eb, qb;
    hb = hvld_cnt;
    eb = herr_cnt;
    qb = got_q.size();
    send_hdr(h);
    wait_hdr(tag);
    check({tag, "_hdr_vld"}, 32'(hvld_cnt - hb), 32'd0);
    check({tag, "_hdr_err"}, 32'(herr_cnt - eb), 32'd1);
    check({tag, "_busy_drain"}, 32'(bus.busy), 32'd1);
    send_payload(7'b1011101, 0, 1'b0, PAYLOAD_BITS);
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_no_bytes"}, 32'(got_q.size() - qb), 32'd0);
  endtask

  initial begin
    int qb;
    int eop_seen;

    bus.sig_bit = 1'b0;
    bus.sig_vld = 1'b0;
    bus.pl_bit  = 1'b0;
    bus.pl_vld  = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hdr_vld", 32'(bus.hdr_vld), 32'd0);
    check("rst_byte_vld", 32'(bus.byte_vld), 32'd0);
    check("rst_rate", 32'(bus.rate), 32'd0);
    check("rst_length", 32'(bus.length), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Legal frame, bytes 0x00..0x63
    for (int i = 0; i < 100; i++) psdu[i] = 8'(i);
    run_accept("len100", 4'b1101, 100, 7'b1011101, 1'b0);

    // Header rejections: parity, LENGTH too long, LENGTH zero, illegal rate
    run_reject("parity", make_hdr(4'b1101, 12'd100, 1'b0, 1'b1));
    run_reject("len538", make_hdr(4'b1101, 12'd538, 1'b0, 1'b0));
    run_reject("len0", make_hdr(4'b1101, 12'd0, 1'b0, 1'b0));
    run_reject("rate0101", make_hdr(4'b0101, 12'd10, 1'b0, 1'b0));

    // Longest legal frame
    for (int i = 0; i < 537; i++) psdu[i] = 8'((i * 7 + 3) & 8'hff);
    run_accept("len537", 4'b1011, 537, 7'b1011101, 1'b0);

    // Single byte with pl_vld toggling; byte one cycle after its 8th bit
    psdu[0] = 8'ha5;
    qb = got_q.size();
    run_accept("len1", 4'b1111, 1, 7'b0110011, 1'b1);
    if (got_q.size() > qb) check("len1_latency", 32'(got_q[qb].cyc), 32'(last_data_cyc + 1));
    else check("len1_latency_present", 32'd0, 32'd1);

    // Back-to-back frames with different seeds
    for (int i = 0; i < 20; i++) psdu[i] = 8'(i) ^ 8'h5a;
    run_accept("b2b_a", 4'b1101, 20, 7'b1011101, 1'b0);
    for (int i = 0; i < 30; i++) psdu[i] = 8'(255 - i * 3);
    run_accept("b2b_b", 4'b1001, 30, 7'b1111111, 1'b0);

    // Reset in the middle of byte 40
    for (int i = 0; i < 100; i++) psdu[i] = 8'(i) ^ 8'h3c;
    qb = got_q.size();
    send_hdr(make_hdr(4'b1101, 12'd100, 1'b0, 1'b0));
    wait_hdr("rst_mid");
    send_payload(7'b1011101, 100, 1'b0, 16 + 8 * 40 + 4);
    check_bytes("rst_mid", qb, 40, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_byte_vld", 32'(bus.byte_vld), 32'd0);
    check("rst_mid_byte_out", 32'(bus.byte_out), 32'd0);
    check("rst_mid_rate", 32'(bus.rate), 32'd0);
    check("rst_mid_length", 32'(bus.length), 32'd0);
    check("rst_mid_eop", 32'(bus.byte_eop), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    eop_seen = 0;
    for (int i = qb; i < got_q.size(); i++) if (got_q[i].eop) eop_seen++;
    check("rst_mid_no_eop", 32'(eop_seen), 32'd0);
    check("rst_mid_no_more", 32'(got_q.size() - qb), 32'd40);

    for (int i = 0; i < 100; i++) psdu[i] = 8'(i * 5 + 1);
    run_accept("post_rst", 4'b1101, 100, 7'b1111111, 1'b0);

    check("stray_sop_eop", 32'(stray), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_descram_packer.md
Name: rx_descram_packer

Overview:
- Sits directly downstream of the OFDM receiver (RECV).
- Consumes its serial SIGNAL-field bits (do_signal/do_signal_vld) and serial decoded payload bits (do_payload/do_payload_vld).
- Parses and checks the 24-bit SIGNAL header, recovers the 802.11a scrambler seed from the SERVICE field, descrambles the PSDU, strips SERVICE/tail/pad, and emits an LSB-first packed byte stream with frame delimiters.

Parameters:
- PAYLOAD_BITS, 4320, decoded payload bits delivered per frame (SERVICE + PSDU + tail + pad).
- LEN_W, 12, width of the LENGTH field in bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sig_bit  in  1  SIGNAL-field bit (from do_signal)
- sig_vld  in  1  sig_bit qualifier (from do_signal_vld)
- pl_bit  in  1  payload bit (from do_payload)
- pl_vld  in  1  pl_bit qualifier (from do_payload_vld)
- hdr_vld  out  1  one-cycle pulse, header accepted
- hdr_err  out  1  one-cycle pulse, header rejected
- rate  out  4  RATE field, held from hdr_vld until next header
- length  out  LEN_W  LENGTH field in bytes, held like rate
- byte_out  out  8  descrambled PSDU byte
- byte_vld  out  1  byte_out qualifier
- byte_sop  out  1  first byte of frame (with byte_vld)
- byte_eop  out  1  last byte of frame (with byte_vld)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst high at clk edge): FSM→IDLE; all counters, the shift register and the scrambler state cleared; every output 0. Reset mid-frame aborts the frame; no eop is emitted.
- SIGNAL bit order (first received = bit0):
  - RATE = bits0-3
  - reserved = bit4
  - LENGTH = bits5-16, LSB first
  - parity = bit17, even parity over bits0-17
  - tail = bits18-23
- FSM states: IDLE, SIG, PL_SEED, PL_SVC, PL_DATA, PL_DRAIN.
- IDLE:
  - sig_vld=1 → capture bit0, go to SIG.
  - pl_vld ignored.
- SIG: shift in bits on sig_vld. On the 24th bit, evaluate on the next cycle; pulse exactly one of hdr_vld/hdr_err. Reject the header when any of these holds:
  - parity error
  - RATE[3]==0 (invalid rate code)
  - reserved bit = 1
  - LENGTH==0
  - 8*LENGTH+22 > PAYLOAD_BITS
- After the header:
  - accept → PL_SEED
  - reject → PL_DRAIN; the payload is still consumed so the frame bit count stays aligned
- Payload bit counter pcnt counts pl_vld bits, 0..PAYLOAD_BITS-1.
- PL_SEED: pcnt 0-6. scr <= {scr[5:0], pl_bit}; no output. After 7 bits → PL_SVC.
- PL_SVC: pcnt 7-15, descrambled and discarded.
  - Descramble rule, per bit: fb = scr[6]^scr[3]; d = pl_bit^fb; scr <= {scr[5:0], fb}.
  - After pcnt 15 → PL_DATA.
- PL_DATA: descramble each bit; pack LSB-first (first bit → byte_out[0]).
  - On the 8th bit, register the byte; byte_vld is high 1 cycle after the 8th bit's pl_vld cycle (latency 1).
  - byte_sop on byte 0; byte_eop on byte LENGTH-1.
  - After LENGTH bytes → PL_DRAIN.
- PL_DRAIN: discard bits until pcnt reaches PAYLOAD_BITS-1 → IDLE.
  - If sig_vld arrives while pl_vld has been low for the whole frame remainder, the new header still waits until the drain completes.
- sig_vld asserted in any PL_* state: ignored.
- pl_vld gaps: all states hold; the counters and scr advance only on pl_vld.
- Single-byte frame (LENGTH=1): byte_sop and byte_eop assert together.
- Maximum LENGTH with PAYLOAD_BITS=4320: 537; LENGTH=537 accepted, 538 rejected.

Decomposition:
- Shared package/include: state encodings, SIG field bit offsets, SVC_BITS=16, SEED_BITS=7, TAIL_BITS=6, HDR_BITS=24.
- One sub-module: rx_descrambler.
  - Ports: clk, rst, load, step, din, dout.
  - Contains the 7-bit seed-load / x^7+x^4+1 descramble logic.
- The FSM, header parser and byte packer stay in the top level.

Test Plan:
- Legal header, RATE=1101, LENGTH=100, parity correct; payload scrambled with seed 1011101, PSDU bytes 0x00..0x63 → hdr_vld pulse; rate=1101; length=100; 100 byte_vld pulses with values 0x00..0x63; sop on 0x00, eop on 0x63; busy falls after the 4320th pl_vld.
- Header with bit17 flipped → hdr_err pulse, no hdr_vld, no byte_vld for the full 4320-bit payload, then returns to IDLE.
- LENGTH=537 accepted with 537 bytes out; LENGTH=538 → hdr_err; LENGTH=0 → hdr_err.
- LENGTH=1, PSDU byte 0xA5, pl_vld toggling every other cycle → single byte 0xA5 with sop=eop=1, one cycle after its 8th valid bit.
- Two back-to-back frames with different seeds (1011101, then 1111111) → both decode correctly; scr reloads per frame.
- rst asserted for 1 cycle at byte 40 of a LENGTH=100 frame → all outputs 0 next cycle, no eop; the following frame decodes correctly.
